uart_tx_frame_ctrl: RTL
=======================

Name: uart_tx_frame_ctrl

Overview:
- UART transmit frame controller that sits directly upstream of the 8-bit serializer. It drives the serializer's load and enable controls and consumes its serial bit output.
- It wraps each data word into a line frame: start bit (0), DATA_WIDTH data bits LSB-first taken from the serializer, optional parity bit, and stop bit (1).
- tx_out drives the UART TX pad.

Parameters:
- DATA_WIDTH, 8, data bits per frame. Must match the serializer width. Sizes the bit counter at clog2(DATA_WIDTH) bits.

Ports:
- clk  input  1  system clock; one bit per cycle (prescaling is handled outside this block)
- rst  input  1  synchronous, active-high reset
- p_data  input  DATA_WIDTH  parallel word; sampled for parity on the accept cycle
- data_valid  input  1  request to send p_data
- par_en  input  1  1 = insert parity bit; sampled on accept
- par_typ  input  1  0 = even, 1 = odd; sampled on accept
- ser_data  input  1  serial bit from the serializer (its current LSB)
- ser_load  output  1  serializer load strobe
- ser_en  output  1  serializer shift enable
- tx_out  output  1  serial line; idles high
- busy  output  1  high while a frame is in flight

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free.
- Reset (rst=1 at an edge):
  - state=IDLE, bit counter=0, parity latch=0, par_en/par_typ latches=0.
  - Outputs then read tx_out=1, busy=0, ser_load=0, ser_en=0.
  - Applies mid-frame too: the frame is abandoned and the line returns high on the next cycle.
- Accept:
  - In IDLE, data_valid=1 makes ser_load=1 combinationally in that same cycle.
  - At that edge: state goes to START; par_bit latches ^p_data XOR par_typ; par_en and par_typ latch.
  - data_valid is ignored in every other state. No queueing; the source holds the request or retries.
- IDLE:
  - tx_out=1, busy=0.
- START (1 cycle):
  - tx_out=0, ser_en=0.
  - Next state: DATA, counter=0.
- DATA (DATA_WIDTH cycles):
  - tx_out=ser_data, ser_en=1, so the serializer shifts at the end of each DATA cycle.
  - Counter increments each cycle.
  - On the cycle with counter==DATA_WIDTH-1: go to PARITY if the latched par_en=1, else STOP. Counter returns to 0.
- PARITY (1 cycle):
  - tx_out=latched par_bit, ser_en=0.
  - Next state: STOP.
- STOP (1 cycle):
  - tx_out=1, ser_en=0.
  - Next state: IDLE.
- Output timing:
  - busy=(state!=IDLE) and is decoded from the state register.
  - tx_out is a combinational mux of registered signals only (state, par_bit, ser_data). It must not depend on data_valid.
- Frame length and throughput:
  - Frame = 10 cycles without parity, 11 with parity (default width).
  - One mandatory IDLE cycle between frames, so back-to-back throughput is one frame per 11 (or 12) cycles.
- ser_done is not used; this block owns bit counting.
- par_en, par_typ and p_data changing mid-frame have no effect on the frame in flight.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles with tx_out=1 in both. A 1-bit sub-counter tracks the two cycles, and busy stays high through both. Frame = 11 cycles without parity, 12 with parity.
- Undefined: single STOP cycle as specified above.

Test Plan:
- Reset then idle, data_valid=0 for 20 cycles -> tx_out=1, busy=0, ser_load=0, ser_en=0 throughout.
- p_data=0xA5, par_en=0, one-cycle data_valid -> ser_load high for exactly 1 cycle; tx_out sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); busy high 10 cycles; ser_en high for exactly 8 cycles.
- p_data=0xA5 with par_en=1: par_typ=0 -> parity bit 0; par_typ=1 -> parity bit 1. busy high 11 cycles in both cases.
- data_valid held high continuously with p_data=0x3C, par_en=0 -> frames separated by exactly 1 IDLE cycle (tx_out=1); pulses toggled during a frame are ignored.
- rst=1 for one cycle during DATA bit 3 -> next cycle tx_out=1, busy=0, state IDLE; a new data_valid afterwards produces a complete, correct frame.
- With UART_TX_TWO_STOP_EN defined, p_data=0xFF, par_en=1, par_typ=0 -> sequence 0, eight 1s, parity 0, then 1,1; busy high 12 cycles.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
//
// UART transmit frame controller placed directly upstream of a DATA_WIDTH-bit
// serializer. It wraps each word as a line frame: a start bit (0), DATA_WIDTH
// data bits LSB-first taken from the serializer, an optional parity bit, and a
// stop bit (1). The block counts the data bits itself, so the serializer's done
// flag is not used.
//
// Ports:
//   clk         system clock, one line bit per cycle
//   rst         synchronous, active-high reset
//   p_data      parallel word; its parity is captured on the accept cycle
//   data_valid  send request; only honoured in IDLE, never queued
//   par_en      1 = insert a parity bit (captured on accept)
//   par_typ     0 = even, 1 = odd (captured on accept)
//   ser_data    serializer's current LSB
//   ser_load    serializer load strobe (combinational, accept cycle)
//   ser_en      serializer shift enable (high for every DATA cycle)
//   tx_out      serial line to the TX pad; idles high
//   busy        high while a frame is in flight
//
// Build option:
//   UART_TX_TWO_STOP_EN  when defined, STOP lasts two cycles instead of one.

module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    output logic                  ser_load,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned    CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // par_bit_q holds the data parity only; the even/odd selection is folded in
    // from par_typ_q when the parity bit is driven. The line value is the same
    // as latching (^p_data ^ par_typ) directly.
    logic            par_bit_q, par_bit_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
`ifdef UART_TX_TWO_STOP_EN
    logic            stop_cnt_q, stop_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt_q;
`endif
        ser_load   = 1'b0;
        ser_en     = 1'b0;
        tx_out     = 1'b1;

        unique case (state_q)
            StIdle: begin
                // data_valid only steers the load strobe and next state; tx_out
                // stays a function of registered state.
                if (data_valid) begin
                    ser_load  = 1'b1;
                    state_d   = StStart;
                    par_bit_d = ^p_data;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                end
            end
            StStart: begin
                tx_out  = 1'b0;
                cnt_d   = '0;
                state_d = StData;
            end
            StData: begin
                tx_out = ser_data;
                ser_en = 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                tx_out  = par_bit_q ^ par_typ_q;
                state_d = StStop;
            end
            StStop: begin
`ifdef UART_TX_TWO_STOP_EN
                if (stop_cnt_q) begin
                    stop_cnt_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    stop_cnt_d = 1'b1;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule
